// File: rtl/keypad_press_encoder.sv
// keypad_press_encoder: synchronise, debounce and encode 4 raw push buttons into a one-shot key strobe
// Ports: clk system clock; rst async active-high reset; btn_raw raw button levels (N,S,E,W);
//        btn last accepted pattern; is_a_key_pressed one-cycle strobe; busy high outside IDLE
module keypad_press_encoder #(
   parameter int DEBOUNCE_CYCLES = 2500000,
   parameter int CNT_W = $clog2(DEBOUNCE_CYCLES)
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] btn_raw,
   output logic [3:0] btn,
   output logic       is_a_key_pressed,
   output logic       busy
);
   typedef enum logic [2:0] {IDLE, PRESS_DB, EMIT, HOLD, RELEASE_DB} state_t;
   state_t r_state, w_state_nxt;
   logic [3:0] r_s1, r_sync, r_cand, w_cand_nxt;
   logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
   logic w_cnt_done;
   assign w_cnt_done = r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1);
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         r_s1             <= '0;
         r_sync           <= '0;
         r_state          <= IDLE;
         r_cand           <= '0;
         r_cnt            <= '0;
         btn              <= '0;
         is_a_key_pressed <= 1'b0;
         busy             <= 1'b0;
      end else begin
         r_s1             <= btn_raw;
         r_sync           <= r_s1;
         r_state          <= w_state_nxt;
         r_cand           <= w_cand_nxt;
         r_cnt            <= w_cnt_nxt;
         // outputs are registered from the next state so the strobe lines up with EMIT
         is_a_key_pressed <= w_state_nxt == EMIT;
         busy             <= w_state_nxt != IDLE;
         if (w_state_nxt == EMIT) btn <= w_cand_nxt;
      end
   always_comb begin
      w_state_nxt = r_state;
      w_cand_nxt  = r_cand;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         IDLE:
            if (r_sync != 4'd0) begin
               w_state_nxt = PRESS_DB;
               w_cand_nxt  = r_sync;
               w_cnt_nxt   = '0;
            end
         PRESS_DB:
            if (r_sync == 4'd0) w_state_nxt = IDLE;
            else if (r_sync != r_cand) begin
               // a different pattern restarts the debounce on that pattern
               w_cand_nxt = r_sync;
               w_cnt_nxt  = '0;
            end else if (w_cnt_done) w_state_nxt = EMIT;
            else w_cnt_nxt = r_cnt + CNT_W'(1);
         EMIT:
            w_state_nxt = HOLD;
         HOLD:
            if (r_sync == 4'd0) begin
               w_state_nxt = RELEASE_DB;
               w_cnt_nxt   = '0;
            end
         RELEASE_DB:
            // any activity during release is bounce, never a new press
            if (r_sync != 4'd0) w_state_nxt = HOLD;
            else if (w_cnt_done) w_state_nxt = IDLE;
            else w_cnt_nxt = r_cnt + CNT_W'(1);
         default:
            w_state_nxt = IDLE;
      endcase
   end
endmodule

// File: tb/tb_keypad_press_encoder.sv
// tb_keypad_press_encoder: self-checking bench for keypad_press_encoder with DEBOUNCE_CYCLES=4
module tb_keypad_press_encoder;
   localparam int D = 4;
   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [3:0] btn_raw = 4'd0;
   logic [3:0] btn;
   logic       is_a_key_pressed;
   logic       busy;
   int checks = 0;
   int errors = 0;
   int seg_pulses = 0;
   keypad_press_encoder #(.DEBOUNCE_CYCLES(D)) dut (
      .clk(clk),
      .rst(rst),
      .btn_raw(btn_raw),
      .btn(btn),
      .is_a_key_pressed(is_a_key_pressed),
      .busy(busy)
   );
   always #5 clk = ~clk;
   // reference: a press is accepted after D+1 identical nonzero synced samples while armed;
   // after a strobe one sample is ignored, then D+1 consecutive zero samples re-arm
   logic [3:0] m_s1, m_sync, m_btn, m_pat;
   bit m_armed, m_skip, m_pulse;
   int m_run, m_zrun;
   task automatic model_reset();
      m_s1 = 0; m_sync = 0; m_btn = 0; m_pat = 0;
      m_armed = 1; m_skip = 0; m_pulse = 0; m_run = 0; m_zrun = 0;
   endtask
   task automatic model_edge(input logic [3:0] raw);
      m_pulse = 0;
      if (m_armed) begin
         if (m_sync == 4'd0) m_run = 0;
         else if (m_run > 0 && m_sync == m_pat) m_run++;
         else begin
            m_pat = m_sync;
            m_run = 1;
         end
         if (m_run == D + 1) begin
            m_pulse = 1; m_btn = m_pat; m_armed = 0; m_skip = 1; m_run = 0; m_zrun = 0;
         end
      end else if (m_skip) m_skip = 0;
      else begin
         m_zrun = (m_sync == 4'd0) ? m_zrun + 1 : 0;
         if (m_zrun == D + 1) m_armed = 1;
      end
      m_sync = m_s1;
      m_s1 = raw;
   endtask
   function automatic logic exp_busy();
      return !(m_armed && m_run == 0);
   endfunction
   task automatic step(input logic [3:0] raw);
      btn_raw = raw;
      @(posedge clk);
      model_edge(raw);
      #1;
      checks++;
      if (is_a_key_pressed !== m_pulse || btn !== m_btn || busy !== exp_busy()) begin
         errors++;
         $display("FAIL model t=%0t: strobe=%b btn=%b busy=%b expected strobe=%b btn=%b busy=%b",
                  $time, is_a_key_pressed, btn, busy, m_pulse, m_btn, exp_busy());
      end
      if (is_a_key_pressed === 1'b1) seg_pulses++;
   endtask
   task automatic do_reset();
      rst = 1'b1;
      #1;
      checks++;
      if (btn !== 4'd0 || is_a_key_pressed !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL reset: btn=%b strobe=%b busy=%b expected btn=0000 strobe=0 busy=0",
                  btn, is_a_key_pressed, busy);
      end
      model_reset();
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask
   typedef struct {
      logic [3:0] raw;
      int         len;
      int         pulses;
      logic [3:0] ebtn;
      logic       ebusy;
   } vec_t;
   vec_t tbl[$];
   task automatic press_latency(input logic [3:0] p, input string name);
      int lat;
      logic [3:0] cap;
      lat = -1;
      cap = 4'd0;
      for (int k = 1; k <= 12; k++) begin
         step(p);
         if (is_a_key_pressed === 1'b1 && lat < 0) begin
            lat = k;
            cap = btn;
         end
      end
      checks++;
      if (lat != D + 3 || cap !== p) begin
         errors++;
         $display("FAIL %s: strobe edge=%0d btn=%b expected edge=%0d btn=%b", name, lat, cap, D + 3, p);
      end
      for (int k = 0; k < 12; k++) step(4'd0);
   endtask
   initial begin
      tbl.push_back('{4'b0100, 20, 1, 4'b0100, 1'b1});
      tbl.push_back('{4'b0000, 12, 0, 4'b0100, 1'b0});
      tbl.push_back('{4'b0001,  2, 0, 4'b0100, 1'b0});
      tbl.push_back('{4'b0000,  1, 0, 4'b0100, 1'b1});
      tbl.push_back('{4'b0001, 10, 1, 4'b0001, 1'b1});
      tbl.push_back('{4'b0000, 12, 0, 4'b0001, 1'b0});
      tbl.push_back('{4'b1000,  3, 0, 4'b0001, 1'b1});
      tbl.push_back('{4'b0000,  8, 0, 4'b0001, 1'b0});
      tbl.push_back('{4'b0010, 12, 1, 4'b0010, 1'b1});
      tbl.push_back('{4'b0000,  1, 0, 4'b0010, 1'b1});
      tbl.push_back('{4'b0010,  2, 0, 4'b0010, 1'b1});
      tbl.push_back('{4'b0000, 10, 0, 4'b0010, 1'b0});
      tbl.push_back('{4'b0100, 12, 1, 4'b0100, 1'b1});
      tbl.push_back('{4'b0000, 12, 0, 4'b0100, 1'b0});
      tbl.push_back('{4'b0001, 12, 1, 4'b0001, 1'b1});
      tbl.push_back('{4'b0000, 12, 0, 4'b0001, 1'b0});
      tbl.push_back('{4'b0010, 12, 1, 4'b0010, 1'b1});
      tbl.push_back('{4'b0000, 12, 0, 4'b0010, 1'b0});
      tbl.push_back('{4'b0001, 12, 1, 4'b0001, 1'b1});
      tbl.push_back('{4'b0000, 12, 0, 4'b0001, 1'b0});
      tbl.push_back('{4'b0011, 12, 1, 4'b0011, 1'b1});
      tbl.push_back('{4'b0000, 12, 0, 4'b0011, 1'b0});
      tbl.push_back('{4'b0100,  3, 0, 4'b0011, 1'b1});
      tbl.push_back('{4'b0010, 12, 1, 4'b0010, 1'b1});
      tbl.push_back('{4'b0000, 12, 0, 4'b0010, 1'b0});
      tbl.push_back('{4'b0001, 12, 1, 4'b0001, 1'b1});
      tbl.push_back('{4'b1000, 12, 0, 4'b0001, 1'b1});
      tbl.push_back('{4'b0000, 12, 0, 4'b0001, 1'b0});
      #2;
      do_reset();
      for (int i = 0; i < tbl.size(); i++) begin
         seg_pulses = 0;
         for (int k = 0; k < tbl[i].len; k++) step(tbl[i].raw);
         checks++;
         if (seg_pulses != tbl[i].pulses || btn !== tbl[i].ebtn || busy !== tbl[i].ebusy) begin
            errors++;
            $display("FAIL vec%0d: pulses=%0d btn=%b busy=%b expected pulses=%0d btn=%b busy=%b",
                     i, seg_pulses, btn, busy, tbl[i].pulses, tbl[i].ebtn, tbl[i].ebusy);
         end
      end
      press_latency(4'b0100, "latency");
      for (int k = 0; k < 5; k++) step(4'b0010);
      checks++;
      if (busy !== 1'b1 || is_a_key_pressed !== 1'b0) begin
         errors++;
         $display("FAIL mid_press_db: busy=%b strobe=%b expected busy=1 strobe=0", busy, is_a_key_pressed);
      end
      btn_raw = 4'b0010;
      do_reset();
      press_latency(4'b0010, "after_reset");
      for (int s = 0; s < 400; s++) begin
         logic [3:0] p;
         int n;
         p = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
         n = $urandom_range(1, 10);
         if ($urandom_range(0, 39) == 0) do_reset();
         for (int k = 0; k < n; k++) step(p);
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
